npc_predict_unit: RTL and testbench

- Next-PC generator for the IF stage. Produces the next fetch address from a combinational static/dynamic prediction on the fetched instruction.
- Keeps a parametrised-depth record of in-flight predictions and checks each one when its branch resolves downstream.
- Raises redirect with the corrected PC on a direction or target mispredict, then flushes the record.
- Trains a PC-indexed table of 2-bit saturating counters.

---
 rtl/npc_predict_unit.sv | 138 +++++++++++++
 tb/tb_npc_predict_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_predict_unit.sv
// Next-PC generator for the fetch stage.
// Predicts the next fetch address from the instruction in IF (JAL always taken,
// conditional branches follow a PC-indexed table of 2-bit counters), remembers
// every prediction until its instruction resolves, and raises a redirect with
// the corrected PC when a resolved outcome disagrees with what was predicted.
module npc_predict_unit #(
  parameter int                  WIDTH_PC      = 32,
  parameter int                  WIDTH_INST    = 32,
  parameter int                  RESOLVE_DEPTH = 2,
  parameter int                  BHT_ENTRIES   = 64,
  parameter logic [WIDTH_PC-1:0] RESET_PC      = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stop_IF,
  input  logic [WIDTH_PC-1:0]   current_pc,
  input  logic [WIDTH_INST-1:0] inst,
  input  logic                  res_valid,
  input  logic                  res_is_branch,
  input  logic                  res_taken,
  input  logic [WIDTH_PC-1:0]   res_pc,
  input  logic [WIDTH_PC-1:0]   res_target,
  output logic [WIDTH_PC-1:0]   npc,
  output logic                  redirect,
  output logic                  pred_taken
);

  localparam int                  IDX_W     = $clog2(BHT_ENTRIES);
  localparam logic [6:0]          OP_JAL    = 7'b1101111;
  localparam logic [6:0]          OP_BRANCH = 7'b1100011;
  localparam logic [WIDTH_PC-1:0] PC_STEP   = WIDTH_PC'(4);

  // Branch history table: 2-bit saturating counters, MSB is the taken prediction
  logic [1:0]          bht        [BHT_ENTRIES];

  // Prediction record, slot 0 holds the oldest in-flight prediction
  logic                rec_valid  [RESOLVE_DEPTH];
  logic                rec_taken  [RESOLVE_DEPTH];
  logic [WIDTH_PC-1:0] rec_target [RESOLVE_DEPTH];

  logic [20:0]         j_imm;
  logic [12:0]         b_imm;
  logic [WIDTH_PC-1:0] seq_pc;
  logic [WIDTH_PC-1:0] j_target;
  logic [WIDTH_PC-1:0] b_target;
  logic [WIDTH_PC-1:0] pred_pc;
  logic [IDX_W-1:0]    pred_idx;
  logic [IDX_W-1:0]    res_idx;
  logic                mispredict;
  logic                train;

  assign j_imm    = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign b_imm    = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign seq_pc   = current_pc + PC_STEP;
  assign j_target = current_pc + WIDTH_PC'($signed(j_imm));
  assign b_target = current_pc + WIDTH_PC'($signed(b_imm));
  assign pred_idx = current_pc[IDX_W+1:2];
  assign res_idx  = res_pc[IDX_W+1:2];

  // A resolved outcome is only judged against a live prediction; squashed bubbles are ignored
  assign mispredict = res_valid & rec_valid[0] &
                      ((rec_taken[0] != res_taken) |
                       (res_taken & (rec_target[0] != res_target)));
  assign redirect   = mispredict;
  assign train      = res_valid & res_is_branch & rec_valid[0];

  // Static/dynamic direction and target prediction for the instruction in IF
  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = seq_pc;
    case (inst[6:0])
      OP_JAL: begin
        pred_taken = 1'b1;
        pred_pc    = j_target;
      end
      OP_BRANCH: begin
        pred_taken = bht[pred_idx][1];
        pred_pc    = bht[pred_idx][1] ? b_target : seq_pc;
      end
      default: begin
        pred_taken = 1'b0;
        pred_pc    = seq_pc;
      end
    endcase
  end

  // Next fetch address: reset, then mispredict correction, then stall hold, then prediction
  always_comb begin
    npc = pred_pc;
    if (!rst_n) begin
      npc = RESET_PC;
    end else if (mispredict) begin
      npc = res_taken ? res_target : (res_pc + PC_STEP);
    end else if (stop_IF) begin
      npc = current_pc;
    end
  end

  // Record shifts toward slot 0 on each unstalled fetch; a mispredict wipes every slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RESOLVE_DEPTH; i++) begin
        rec_valid[i]  <= 1'b0;
        rec_taken[i]  <= 1'b0;
        rec_target[i] <= '0;
      end
    end else if (mispredict) begin
      for (int i = 0; i < RESOLVE_DEPTH; i++) begin
        rec_valid[i] <= 1'b0;
      end
    end else if (!stop_IF) begin
      for (int i = 0; i < RESOLVE_DEPTH - 1; i++) begin
        rec_valid[i]  <= rec_valid[i+1];
        rec_taken[i]  <= rec_taken[i+1];
        rec_target[i] <= rec_target[i+1];
      end
      rec_valid[RESOLVE_DEPTH-1]  <= 1'b1;
      rec_taken[RESOLVE_DEPTH-1]  <= pred_taken;
      rec_target[RESOLVE_DEPTH-1] <= pred_pc;
    end
  end

  // Counter training on every live branch resolution, independent of stall or redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (train) begin
      if (res_taken && (bht[res_idx] != 2'b11)) begin
        bht[res_idx] <= bht[res_idx] + 2'b01;
      end else if (!res_taken && (bht[res_idx] != 2'b00)) begin
        bht[res_idx] <= bht[res_idx] - 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_npc_predict_unit.sv
// Self-checking bench for npc_predict_unit: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_npc_predict_unit;

  localparam int          D        = 2;
  localparam int          BHT      = 64;
  localparam logic [31:0] RST_PC   = 32'h0000_0080;
  localparam int          K_ADDI   = 0;
  localparam int          K_JAL    = 1;
  localparam int          K_BR     = 2;
  localparam int          K_JALR   = 3;

  logic        clk;
  logic        rst_n;
  logic        stop_IF;
  logic [31:0] current_pc;
  logic [31:0] inst;
  logic        res_valid;
  logic        res_is_branch;
  logic        res_taken;
  logic [31:0] res_pc;
  logic [31:0] res_target;
  logic [31:0] npc;
  logic        redirect;
  logic        pred_taken;

  int total = 0;
  int bad   = 0;

  npc_predict_unit #(
    .WIDTH_PC(32), .WIDTH_INST(32), .RESOLVE_DEPTH(D),
    .BHT_ENTRIES(BHT), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stop_IF(stop_IF), .current_pc(current_pc),
    .inst(inst), .res_valid(res_valid), .res_is_branch(res_is_branch),
    .res_taken(res_taken), .res_pc(res_pc), .res_target(res_target),
    .npc(npc), .redirect(redirect), .pred_taken(pred_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: in-flight predictions as a queue, counters as plain integers
  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
  } slot_t;

  slot_t       slots[$];
  int          cnt[BHT];
  logic        m_taken;
  logic [31:0] m_ppc;
  logic        m_mis;

  function automatic logic [31:0] encode(input int kind, input logic [31:0] imm);
    case (kind)
      K_JAL:   return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
      K_BR:    return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b001, imm[4:1], imm[11], 7'b1100011};
      K_JALR:  return {imm[11:0], 5'd1, 3'b000, 5'd1, 7'b1100111};
      default: return {imm[11:0], 5'd1, 3'b000, 5'd1, 7'b0010011};
    endcase
  endfunction

  function automatic int bhtIndex(input logic [31:0] pc);
    return int'((pc >> 2) % 32'(BHT));
  endfunction

  task automatic modelReset();
    slot_t empty;
    empty = '0;
    slots.delete();
    for (int i = 0; i < D; i++) slots.push_back(empty);
    for (int i = 0; i < BHT; i++) cnt[i] = 1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and compare combinational outputs with the model
  task automatic applyStimulus(input logic stop, input logic [31:0] pc, input int kind,
                               input logic [31:0] imm, input logic rv, input logic rb,
                               input logic rt, input logic [31:0] rpc, input logic [31:0] rtgt);
    logic [31:0] exp_npc;
    stop_IF       = stop;
    current_pc    = pc;
    inst          = encode(kind, imm);
    res_valid     = rv;
    res_is_branch = rb;
    res_taken     = rt;
    res_pc        = rpc;
    res_target    = rtgt;
    #1;
    m_taken = (kind == K_JAL) || ((kind == K_BR) && (cnt[bhtIndex(pc)] >= 2));
    m_ppc   = m_taken ? pc + imm : pc + 32'd4;
    m_mis   = rv && slots[0].valid &&
              ((slots[0].taken != rt) || (rt && (slots[0].target != rtgt)));
    if (m_mis)     exp_npc = rt ? rtgt : rpc + 32'd4;
    else if (stop) exp_npc = pc;
    else           exp_npc = m_ppc;
    checkOutput("pred_taken", {31'd0, pred_taken}, {31'd0, m_taken});
    checkOutput("redirect", {31'd0, redirect}, {31'd0, m_mis});
    checkOutput("npc", npc, exp_npc);
  endtask

  // Advance the model with the inputs currently applied, then clock the DUT
  task automatic tick();
    slot_t s;
    int    bi;
    if (res_valid && res_is_branch && slots[0].valid) begin
      bi = bhtIndex(res_pc);
      if (res_taken) cnt[bi] = (cnt[bi] == 3) ? 3 : cnt[bi] + 1;
      else           cnt[bi] = (cnt[bi] == 0) ? 0 : cnt[bi] - 1;
    end
    if (m_mis) begin
      for (int i = 0; i < D; i++) slots[i].valid = 1'b0;
    end else if (!stop_IF) begin
      s.valid  = 1'b1;
      s.taken  = m_taken;
      s.target = m_ppc;
      void'(slots.pop_front());
      slots.push_back(s);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] pc);
    applyStimulus(1'b0, pc, K_ADDI, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
  endtask

  // Assert reset asynchronously with a live-looking resolve on the inputs
  task automatic doReset();
    rst_n         = 1'b0;
    stop_IF       = 1'b0;
    current_pc    = 32'h100;
    inst          = encode(K_BR, 32'h40);
    res_valid     = 1'b1;
    res_is_branch = 1'b1;
    res_taken     = 1'b1;
    res_pc        = 32'h100;
    res_target    = 32'h1234;
    #1;
    modelReset();
    checkOutput("rst_npc", npc, RST_PC);
    checkOutput("rst_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("rst_pred", {31'd0, pred_taken}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_npc_hold", npc, RST_PC);
    rst_n     = 1'b1;
    res_valid = 1'b0;
  endtask

  // One branch at 0x400 resolved D cycles after fetch with the given direction
  task automatic branchRound(input logic rt);
    applyStimulus(1'b0, 32'h400, K_BR, 32'h10, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    for (int i = 0; i < D - 1; i++) fill(32'h404 + 32'(4 * i));
    applyStimulus(1'b0, 32'h408, K_ADDI, 32'd0, 1'b1, 1'b1, rt, 32'h400,
                  rt ? 32'h410 : 32'h404);
    tick();
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] tgt;
    int          kind;

    #1;
    doReset();
    fill(32'h40);
    fill(32'h44);
    applyStimulus(1'b0, 32'h48, K_JAL, 32'h100, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();

    $display("[TB] mid-run reset");
    doReset();
    applyStimulus(1'b0, 32'h100, K_BR, 32'h40, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("post_rst_npc", npc, 32'h104);
    tick();

    $display("[TB] jal correctly predicted");
    applyStimulus(1'b0, 32'h200, K_JAL, 32'h20, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("jal_npc", npc, 32'h220);
    tick();
    for (int i = 0; i < D - 1; i++) fill(32'h220 + 32'(4 * i));
    applyStimulus(1'b0, 32'h230, K_ADDI, 32'd0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h220);
    checkOutput("jal_no_redirect", {31'd0, redirect}, 32'd0);
    tick();

    $display("[TB] branch direction mispredict");
    applyStimulus(1'b0, 32'h300, K_BR, 32'h40, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("br300_pred", {31'd0, pred_taken}, 32'd0);
    tick();
    for (int i = 0; i < D - 1; i++) fill(32'h304 + 32'(4 * i));
    applyStimulus(1'b0, 32'h310, K_ADDI, 32'd0, 1'b1, 1'b1, 1'b1, 32'h300, 32'h340);
    checkOutput("br300_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("br300_npc", npc, 32'h340);
    tick();
    applyStimulus(1'b0, 32'h340, K_ADDI, 32'd0, 1'b1, 1'b1, 1'b1, 32'h300, 32'h999);
    checkOutput("flushed_no_redirect", {31'd0, redirect}, 32'd0);
    tick();

    $display("[TB] counter training and saturation");
    doReset();
    branchRound(1'b1);
    branchRound(1'b1);
    applyStimulus(1'b0, 32'h400, K_BR, 32'h10, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("trained_pred", {31'd0, pred_taken}, 32'd1);
    checkOutput("trained_npc", npc, 32'h410);
    tick();
    for (int n = 0; n < 5; n++) branchRound(1'b0);
    applyStimulus(1'b0, 32'h400, K_BR, 32'h10, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("floor_pred", {31'd0, pred_taken}, 32'd0);
    tick();
    branchRound(1'b1);
    branchRound(1'b1);
    applyStimulus(1'b0, 32'h400, K_BR, 32'h10, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("regain_pred", {31'd0, pred_taken}, 32'd1);
    tick();

    $display("[TB] stall then redirect during stall");
    applyStimulus(1'b0, 32'h4F0, K_JAL, 32'h10, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("jal4f0_npc", npc, 32'h500);
    tick();
    for (int i = 0; i < D - 1; i++) fill(32'h500);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b1, 32'h500, K_ADDI, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      checkOutput("stall_npc", npc, 32'h500);
      tick();
    end
    applyStimulus(1'b1, 32'h500, K_ADDI, 32'd0, 1'b1, 1'b0, 1'b0, 32'h4F0, 32'd0);
    checkOutput("stall_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("stall_redirect_npc", npc, 32'h4F4);
    tick();
    applyStimulus(1'b0, 32'h4F4, K_ADDI, 32'd0, 1'b1, 1'b0, 1'b0, 32'h4F0, 32'd0);
    checkOutput("stall_flushed", {31'd0, redirect}, 32'd0);
    tick();

    $display("[TB] jalr target and pc wrap");
    applyStimulus(1'b0, 32'h600, K_JALR, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("jalr_pred", {31'd0, pred_taken}, 32'd0);
    tick();
    for (int i = 0; i < D - 1; i++) fill(32'h604 + 32'(4 * i));
    applyStimulus(1'b0, 32'h610, K_ADDI, 32'd0, 1'b1, 1'b0, 1'b1, 32'h600, 32'h800);
    checkOutput("jalr_redirect", {31'd0, redirect}, 32'd1);
    checkOutput("jalr_npc", npc, 32'h800);
    tick();
    applyStimulus(1'b0, 32'hFFFF_FFFC, K_ADDI, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("wrap_npc", npc, 32'h0);
    tick();
    applyStimulus(1'b0, 32'hFFFF_FFF0, K_JAL, 32'h20, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("wrap_jal_npc", npc, 32'h10);
    tick();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) doReset();
      r    = $urandom;
      kind = int'($urandom_range(0, 3));
      pc   = {($urandom_range(0, 1) == 0) ? 22'd0 : 22'h3FFFFF, r[9:2], 2'b00};
      r    = $urandom;
      if (kind == K_JAL) imm = {{11{r[20]}}, r[20:1], 1'b0};
      else               imm = {{19{r[12]}}, r[12:1], 1'b0};
      tgt  = {$urandom_range(0, 1023), 2'b00};
      if (slots[0].valid && ($urandom_range(0, 1) == 1)) tgt = slots[0].target;
      applyStimulus($urandom_range(0, 4) == 0, pc, kind, imm,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 1) == 1, {22'd0, r[31:24], 2'b00}, tgt);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
